// File: rtl/axi_read_arbiter.sv
// N-master to single AXI3 read channel arbiter: one outstanding burst, ARID = grant index.
// Round-robin (ARB_MODE=0) or fixed priority with index 0 highest (ARB_MODE=1).
module axi_read_arbiter #(
  parameter int unsigned N_MASTERS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ARB_MODE  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            m_arvalid,
  output logic [N_MASTERS-1:0]            m_arready,
  input  logic [N_MASTERS*(ADDR_W+9)-1:0] m_arinfo,
  output logic [N_MASTERS-1:0]            m_rvalid,
  input  logic [N_MASTERS-1:0]            m_rready,
  output logic [ID_W-1:0]                 arid,
  output logic [ADDR_W-1:0]               araddr,
  output logic [3:0]                      arlen,
  output logic [2:0]                      arsize,
  output logic [1:0]                      arburst,
  output logic                            arvalid,
  input  logic                            arready,
  input  logic [ID_W-1:0]                 rid,
  input  logic                            rlast,
  input  logic                            rvalid,
  output logic                            rready
);

  localparam int unsigned GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int unsigned IW = ADDR_W + 9;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   winner;
  logic [GW-1:0]   grant_inc;
  logic [GW-1:0]   scan_idx;
  logic            any_req;
  logic [IW-1:0]   info;
  int unsigned     scan_pos;

  // Scan order starts at rr_ptr in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    winner   = '0;
    any_req  = 1'b0;
    scan_pos = 0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      scan_pos = (ARB_MODE == 0) ? ((32'(rr_ptr) + i) % N_MASTERS) : i;
      scan_idx = GW'(scan_pos);
      if (!any_req && m_arvalid[scan_idx]) begin
        any_req = 1'b1;
        winner  = scan_idx;
      end
    end
  end

  assign grant_inc = (grant == GW'(N_MASTERS - 1)) ? '0 : grant + GW'(1);
  assign info      = m_arinfo[32'(grant) * IW +: IW];

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    arid      = '0;
    araddr    = '0;
    arlen     = '0;
    arsize    = '0;
    arburst   = '0;
    case (state)
      ADDR: begin
        arvalid                      = m_arvalid[grant];
        m_arready[grant]             = arready;
        arid                         = ID_W'(grant);
        {araddr, arlen, arsize, arburst} = info;
      end
      DATA: begin
        m_rvalid[grant] = rvalid;
        rready          = m_rready[grant];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= winner;
            state <= ADDR;
          end
        end
        ADDR: begin
          // Request withdrawn before the handshake: abandon without a transfer.
          if (!m_arvalid[grant])
            state <= IDLE;
          else if (arready)
            state <= DATA;
        end
        DATA: begin
          if (rvalid && m_rready[grant] && rlast) begin
            state <= IDLE;
            if (ARB_MODE == 0)
              rr_ptr <= grant_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rid_matches_grant: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DATA && rvalid) |-> (rid == ID_W'(grant)));

  params_legal: assert property (@(posedge clk)
    (ID_W >= GW) && (N_MASTERS >= 1) && (DATA_W % 8 == 0));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter: a round-robin and a fixed-priority instance, one active at a time.
module tb_axi_read_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned IW = AW + 9;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, sel, rst_rr, rst_fx;
  assign rst_rr = rst_n && !sel;
  assign rst_fx = rst_n && sel;

  logic [N-1:0]    m_arvalid, m_rready;
  logic [N*IW-1:0] m_arinfo;
  logic            arready, rvalid, rlast;
  logic [3:0]      rid;

  logic [N-1:0] r_m_arready, r_m_rvalid, f_m_arready, f_m_rvalid;
  logic [3:0]   r_arid, f_arid, r_arlen, f_arlen;
  logic [31:0]  r_araddr, f_araddr;
  logic [2:0]   r_arsize, f_arsize;
  logic [1:0]   r_arburst, f_arburst;
  logic         r_arvalid, f_arvalid, r_rready, f_rready;

  axi_read_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(32), .ID_W(4), .ARB_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_rr), .m_arvalid(m_arvalid), .m_arready(r_m_arready),
    .m_arinfo(m_arinfo), .m_rvalid(r_m_rvalid), .m_rready(m_rready),
    .arid(r_arid), .araddr(r_araddr), .arlen(r_arlen), .arsize(r_arsize),
    .arburst(r_arburst), .arvalid(r_arvalid), .arready(arready),
    .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(r_rready));

  axi_read_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(32), .ID_W(4), .ARB_MODE(1)) u_fx (
    .clk(clk), .rst_n(rst_fx), .m_arvalid(m_arvalid), .m_arready(f_m_arready),
    .m_arinfo(m_arinfo), .m_rvalid(f_m_rvalid), .m_rready(m_rready),
    .arid(f_arid), .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize),
    .arburst(f_arburst), .arvalid(f_arvalid), .arready(arready),
    .rid(rid), .rlast(rlast), .rvalid(rvalid), .rready(f_rready));

  logic [N-1:0] d_m_arready, d_m_rvalid;
  logic [3:0]   d_arid, d_arlen;
  logic [31:0]  d_araddr;
  logic [2:0]   d_arsize;
  logic [1:0]   d_arburst;
  logic         d_arvalid, d_rready;
  assign d_m_arready = sel ? f_m_arready : r_m_arready;
  assign d_m_rvalid  = sel ? f_m_rvalid  : r_m_rvalid;
  assign d_arid      = sel ? f_arid      : r_arid;
  assign d_arlen     = sel ? f_arlen     : r_arlen;
  assign d_araddr    = sel ? f_araddr    : r_araddr;
  assign d_arsize    = sel ? f_arsize    : r_arsize;
  assign d_arburst   = sel ? f_arburst   : r_arburst;
  assign d_arvalid   = sel ? f_arvalid   : r_arvalid;
  assign d_rready    = sel ? f_rready    : r_rready;

  // Master side: each master holds a request until it has been accepted issued[i]-taken[i] times.
  logic [31:0] info_addr [N];
  logic [3:0]  info_len  [N];
  int unsigned issued [N] = '{default: 0};
  int unsigned taken  [N] = '{default: 0};
  logic        tog = 1'b0;
  logic        toggle_en, arready_en;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      m_arvalid[i]            = (issued[i] != taken[i]);
      m_arinfo[i*IW +: IW]    = {info_addr[i], info_len[i], 3'd2, 2'd1};
    end
  end

  always @(posedge clk) begin
    tog <= ~tog;
    for (int unsigned i = 0; i < N; i++)
      if (m_arvalid[i] && d_m_arready[i]) taken[i] <= taken[i] + 1;
  end

  assign m_rready = toggle_en ? {N{tog}} : '1;

  // Slave: one burst at a time, rvalid held high for every beat, rid echoes the accepted arid.
  logic       busy;
  logic [3:0] beats, rid_q;
  assign arready = arready_en && !busy;
  assign rvalid  = busy;
  assign rlast   = busy && (beats == 4'd0);
  assign rid     = rid_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; beats <= 4'd0; rid_q <= 4'd0;
    end else if (!busy && d_arvalid && arready) begin
      busy <= 1'b1; beats <= d_arlen; rid_q <= d_arid;
    end else if (busy && d_rready) begin
      if (beats == 4'd0) busy <= 1'b0;
      else beats <= beats - 4'd1;
    end
  end

  ar_t         exp_ar   [$];
  logic [1:0]  exp_beat [$];
  int unsigned hs = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the selected DUT shows an AR handshake or an R beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("no_ar_during_burst", 64'(d_arvalid), 64'd0);
      if (d_arvalid && arready) begin
        if (exp_ar.size() == 0) chk("unexpected_ar", 64'(d_araddr), 64'hffff_ffff_ffff_ffff);
        else begin
          ar_t e;
          e = exp_ar.pop_front();
          chk("arid",    64'(d_arid),    64'(e.id));
          chk("araddr",  64'(d_araddr),  64'(e.addr));
          chk("arlen",   64'(d_arlen),   64'(e.len));
          chk("arsize",  64'(d_arsize),  64'd2);
          chk("arburst", 64'(d_arburst), 64'd1);
        end
      end
      if (rvalid) begin
        if (exp_beat.size() == 0) chk("unexpected_beat", 64'(d_m_rvalid), 64'hffff_ffff_ffff_ffff);
        else begin
          logic [1:0]   m;
          logic [N-1:0] oh;
          m  = exp_beat[0];
          oh = N'(1) << m;
          chk("m_rvalid_route", 64'(d_m_rvalid), 64'(oh));
          chk("rready_mirror",  64'(d_rready),   64'(m_rready[m]));
          if (d_rready) begin
            void'(exp_beat.pop_front());
            hs++;
          end
        end
      end
    end
  end

  task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
    ar_t e;
    e.id = id; e.addr = addr; e.len = len;
    exp_ar.push_back(e);
    for (int unsigned b = 0; b <= 32'(len); b++) exp_beat.push_back(id[1:0]);
  endtask

  task automatic set_info(input int unsigned i, input logic [31:0] addr, input logic [3:0] len);
    info_addr[i] = addr;
    info_len[i]  = len;
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0;
    sel   = s;
    exp_ar.delete();
    exp_beat.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int unsigned n;
    n = 0;
    while ((exp_ar.size() != 0 || exp_beat.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_timeout"}, 64'(n >= 300), 64'd0);
    @(negedge clk);
    chk({name, "_idle_arvalid"}, 64'(d_arvalid), 64'd0);
    chk({name, "_idle_rready"},  64'(d_rready),  64'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_arvalid"},   64'(d_arvalid),   64'd0);
    chk({name, "_rready"},    64'(d_rready),    64'd0);
    chk({name, "_m_arready"}, 64'(d_m_arready), 64'd0);
    chk({name, "_m_rvalid"},  64'(d_m_rvalid),  64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int unsigned h0, n;
    rst_n = 1'b0; sel = 1'b0; toggle_en = 1'b0; arready_en = 1'b1;
    for (int unsigned i = 0; i < N; i++) set_info(i, 32'h0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    sync;
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle_after_reset");

    // Single master 1, len 3, arvalid appears one cycle after the request is seen.
    set_info(1, 32'h1fc0_0000, 4'd3);
    push_ar(4'd1, 32'h1fc0_0000, 4'd3);
    sync;
    issued[1]++;
    @(negedge clk);
    chk("latency_idle", 64'(d_arvalid), 64'd0);
    @(negedge clk);
    chk("latency_addr", 64'(d_arvalid), 64'd1);
    wait_done("single");

    // Round-robin, all three requesting twice: 0,1,2,0,1,2.
    do_reset(1'b0);
    set_info(0, 32'h1000_0000, 4'd0);
    set_info(1, 32'h2000_0000, 4'd1);
    set_info(2, 32'h3000_0000, 4'd2);
    push_ar(4'd0, 32'h1000_0000, 4'd0);
    push_ar(4'd1, 32'h2000_0000, 4'd1);
    push_ar(4'd2, 32'h3000_0000, 4'd2);
    push_ar(4'd0, 32'h1000_0000, 4'd0);
    push_ar(4'd1, 32'h2000_0000, 4'd1);
    push_ar(4'd2, 32'h3000_0000, 4'd2);
    sync;
    for (int unsigned i = 0; i < N; i++) issued[i] += 2;
    wait_done("rr");

    // Fixed priority, masters 0 and 2 pending: 0 wins every time until it stops asking.
    do_reset(1'b1);
    push_ar(4'd0, 32'h1000_0000, 4'd0);
    push_ar(4'd0, 32'h1000_0000, 4'd0);
    push_ar(4'd0, 32'h1000_0000, 4'd0);
    push_ar(4'd2, 32'h3000_0000, 4'd2);
    push_ar(4'd2, 32'h3000_0000, 4'd2);
    sync;
    issued[0] += 3;
    issued[2] += 2;
    wait_done("fixed");

    // AR stall: arready low for 5 cycles while the address phase is pending.
    do_reset(1'b0);
    arready_en = 1'b0;
    set_info(0, 32'h0000_1230, 4'd1);
    push_ar(4'd0, 32'h0000_1230, 4'd1);
    sync;
    issued[0]++;
    n = 0;
    while (!d_arvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stall_arvalid_seen", 64'(d_arvalid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_arvalid",   64'(d_arvalid),   64'd1);
      chk("stall_araddr",    64'(d_araddr),    64'h1230);
      chk("stall_m_arready", 64'(d_m_arready), 64'd0);
    end
    sync;
    arready_en = 1'b1;
    wait_done("stall");

    // Master 2 toggles rready every cycle over an 8-beat burst.
    do_reset(1'b0);
    set_info(2, 32'h0000_8000, 4'd7);
    push_ar(4'd2, 32'h0000_8000, 4'd7);
    toggle_en = 1'b1;
    h0 = hs;
    sync;
    issued[2]++;
    wait_done("toggle");
    chk("toggle_beats", 64'(hs - h0), 64'd8);
    toggle_en = 1'b0;

    // Reset mid-burst after advancing rr_ptr to 1; afterwards grant must restart from 0.
    do_reset(1'b0);
    set_info(0, 32'h0000_0100, 4'd0);
    set_info(1, 32'h0000_0200, 4'd7);
    push_ar(4'd0, 32'h0000_0100, 4'd0);
    sync;
    issued[0]++;
    wait_done("pre_reset");
    push_ar(4'd1, 32'h0000_0200, 4'd7);
    h0 = hs;
    sync;
    issued[1]++;
    n = 0;
    while (hs < h0 + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("midburst_reached", 64'(hs - h0), 64'd2);
    #2 rst_n = 1'b0;
    exp_ar.delete();
    exp_beat.delete();
    #1;
    check_outputs_zero("midburst_reset");
    sync;
    rst_n = 1'b1;
    push_ar(4'd0, 32'h0000_0100, 4'd0);
    push_ar(4'd1, 32'h0000_0200, 4'd7);
    sync;
    issued[0]++;
    issued[1]++;
    wait_done("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
